// File: rtl/seq_gen_if.sv
// Handshake/bus bundle between a sequence requester and seq_gen.
// Latency: none, wires only.
// Backpressure: none; start is ignored by the generator while busy is high.
interface seq_gen_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [CNT_W-1:0] gap_len;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    // Requester side: issues start with the frame description, watches the serial line.
    modport master (
        output start, pattern, repeat_cnt, gap_len,
        input  dout, dout_valid, busy, done
    );

    // Generator side.
    modport slave (
        input  start, pattern, repeat_cnt, gap_len,
        output dout, dout_valid, busy, done
    );
endinterface

// File: rtl/seq_gen.sv
// Serial sequence generator: shifts a latched pattern out MSB-first, repeats it with an idle gap.
// Latency: first bit is on dout in the cycle right after the accepting start edge; all outputs registered.
// Backpressure: none on the serial side; start is only sampled while idle (incl. the done cycle).
// Optional: define SEQ_GEN_PARITY_EN to append an even-parity bit after pattern[0] in every frame.
module seq_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic     clock,
    input  logic     reset,
    seq_gen_if.slave bus
);

`ifdef SEQ_GEN_PARITY_EN
    localparam int FRAME_LEN = PAT_W + 1;
`else
    localparam int FRAME_LEN = PAT_W;
`endif
    localparam int BW = $clog2(FRAME_LEN);

    localparam logic [BW-1:0]    LAST_IDX = BW'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_q;        // latched pattern, reloaded for each repeat
    logic [PAT_W-1:0] shreg;        // bits still to send in the current frame, MSB next
    logic [BW-1:0]    bit_idx;      // position of the bit currently on dout
    logic [CNT_W-1:0] frames_left;  // frames still owed after the current one
    logic [CNT_W-1:0] gap_q;        // latched gap length
    logic [CNT_W-1:0] gap_left;     // idle cycles remaining in the current gap
`ifdef SEQ_GEN_PARITY_EN
    logic             par_q;        // even parity of the latched pattern
`endif

    logic dout_r;
    logic dout_valid_r;
    logic busy_r;
    logic done_r;

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

    // Frame sequencer: all outputs are registered here so the serial line is glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pat_q        <= '0;
            shreg        <= '0;
            bit_idx      <= '0;
            frames_left  <= '0;
            gap_q        <= '0;
            gap_left     <= '0;
`ifdef SEQ_GEN_PARITY_EN
            par_q        <= 1'b0;
`endif
            dout_r       <= 1'b0;
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the frame-end branch raises it.
            done_r <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Latch everything; later changes on the inputs are ignored.
                        pat_q        <= bus.pattern;
                        frames_left  <= bus.repeat_cnt;
                        gap_q        <= bus.gap_len;
`ifdef SEQ_GEN_PARITY_EN
                        par_q        <= ^bus.pattern;
`endif
                        dout_r       <= bus.pattern[PAT_W-1];
                        shreg        <= {bus.pattern[PAT_W-2:0], 1'b0};
                        bit_idx      <= '0;
                        dout_valid_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state        <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (bit_idx != LAST_IDX) begin
                        // Mid-frame: advance to the next bit.
                        bit_idx <= bit_idx + BW'(1);
`ifdef SEQ_GEN_PARITY_EN
                        if (bit_idx == BW'(PAT_W - 1)) begin
                            dout_r <= par_q;
                        end else begin
                            dout_r <= shreg[PAT_W-1];
                        end
`else
                        dout_r <= shreg[PAT_W-1];
`endif
                        shreg <= {shreg[PAT_W-2:0], 1'b0};
                    end else if (frames_left != '0) begin
                        // Frame complete, more to send: count it and either restart or idle out.
                        frames_left <= frames_left - CNT_ONE;
                        if (gap_q == '0) begin
                            dout_r       <= pat_q[PAT_W-1];
                            shreg        <= {pat_q[PAT_W-2:0], 1'b0};
                            bit_idx      <= '0;
                            dout_valid_r <= 1'b1;
                        end else begin
                            gap_left     <= gap_q;
                            dout_r       <= 1'b0;
                            dout_valid_r <= 1'b0;
                            state        <= GAP;
                        end
                    end else begin
                        // Final frame complete: drop the line and pulse done.
                        dout_r       <= 1'b0;
                        dout_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        state        <= IDLE;
                    end
                end

                GAP: begin
                    // busy stays high across the gap; the next MSB replaces the last idle cycle.
                    if (gap_left == CNT_ONE) begin
                        dout_r       <= pat_q[PAT_W-1];
                        shreg        <= {pat_q[PAT_W-2:0], 1'b0};
                        bit_idx      <= '0;
                        dout_valid_r <= 1'b1;
                        state        <= SHIFT;
                    end else begin
                        gap_left <= gap_left - CNT_ONE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    dout_r       <= 1'b0;
                    dout_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: table of transfers checked cycle by cycle against a queued expected stream.
// Latency: expected entries start the cycle after the accepting start edge.
// Backpressure: none; hand sequences cover start-while-busy, start-on-done and mid-frame reset.
module tb_seq_gen;

`ifdef SEQ_GEN_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    typedef struct {
        logic [3:0] pat;
        logic [3:0] rep;
        logic [3:0] gap;
        int         exp_frames;
    } vec_t;

    typedef struct packed {
        logic dout;
        logic valid;
        logic busy;
        logic done;
    } obs_t;

    logic clock;
    logic reset;

    seq_gen_if #(.PAT_W(4), .CNT_W(4)) sg ();

    seq_gen #(.PAT_W(4), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    obs_t exp_q[$];
    int   n_chk     = 0;
    int   n_pass    = 0;
    int   obs_valid = 0;
    int   obs_done  = 0;
    bit   chk_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line behaviour for one transfer, ending with the done cycle.
    task automatic push_transfer(input logic [3:0] pat, input logic [3:0] rep, input logic [3:0] gap);
        obs_t e;
        for (int f = 0; f <= int'(rep); f++) begin
            for (int b = 3; b >= 0; b--) begin
                e = '{dout: pat[b], valid: 1'b1, busy: 1'b1, done: 1'b0};
                exp_q.push_back(e);
            end
`ifdef SEQ_GEN_PARITY_EN
            e = '{dout: ^pat, valid: 1'b1, busy: 1'b1, done: 1'b0};
            exp_q.push_back(e);
`endif
            if (f < int'(rep)) begin
                for (int g = 0; g < int'(gap); g++) begin
                    e = '{dout: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b0};
                    exp_q.push_back(e);
                end
            end
        end
        e = '{dout: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b1};
        exp_q.push_back(e);
    endtask

    task automatic push_idle();
        obs_t e;
        e = '{dout: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0};
        exp_q.push_back(e);
    endtask

    // Pulse start for one cycle, then scramble the inputs to prove they were latched.
    task automatic run_transfer(input logic [3:0] pat, input logic [3:0] rep, input logic [3:0] gap);
        @(negedge clock);
        sg.start      = 1'b1;
        sg.pattern    = pat;
        sg.repeat_cnt = rep;
        sg.gap_len    = gap;
        push_transfer(pat, rep, gap);
        push_idle();
        @(negedge clock);
        sg.start      = 1'b0;
        sg.pattern    = 4'($urandom);
        sg.repeat_cnt = 4'($urandom);
        sg.gap_len    = 4'($urandom);
    endtask

    task automatic wait_drain(input string name);
        int budget = 400;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Scoreboard: compare one expected entry per cycle, sampled after the active edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clock);
            #1;
            if (chk_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stream", {28'd0, sg.dout, sg.dout_valid, sg.busy, sg.done}, {28'd0, e});
                if (sg.dout_valid) obs_valid++;
                if (sg.done) obs_done++;
            end
        end
    end

    vec_t v[7];

    initial begin
        v[0] = '{pat: 4'b1011, rep: 4'd0,  gap: 4'd0,  exp_frames: 1};
        v[1] = '{pat: 4'b1011, rep: 4'd2,  gap: 4'd0,  exp_frames: 3};
        v[2] = '{pat: 4'b1011, rep: 4'd1,  gap: 4'd2,  exp_frames: 2};
        v[3] = '{pat: 4'b1001, rep: 4'd0,  gap: 4'd0,  exp_frames: 1};
        v[4] = '{pat: 4'b0110, rep: 4'd3,  gap: 4'd1,  exp_frames: 4};
        v[5] = '{pat: 4'b1100, rep: 4'd15, gap: 4'd0,  exp_frames: 16};
        v[6] = '{pat: 4'b0101, rep: 4'd1,  gap: 4'd15, exp_frames: 2};

        reset         = 1'b1;
        sg.start      = 1'b0;
        sg.pattern    = 4'b0;
        sg.repeat_cnt = 4'd0;
        sg.gap_len    = 4'd0;
        repeat (2) @(negedge clock);
        check("reset_outputs", {28'd0, sg.dout, sg.dout_valid, sg.busy, sg.done}, 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Table-driven transfers.
        for (int i = 0; i < 7; i++) begin
            obs_valid = 0;
            obs_done  = 0;
            run_transfer(v[i].pat, v[i].rep, v[i].gap);
            wait_drain("table");
            check("valid_bits", 32'(obs_valid), 32'(v[i].exp_frames * FL));
            check("done_pulses", 32'(obs_done), 32'd1);
        end

        // start with a different pattern mid-frame must be ignored.
        obs_done = 0;
        @(negedge clock);
        sg.start      = 1'b1;
        sg.pattern    = 4'b1011;
        sg.repeat_cnt = 4'd0;
        sg.gap_len    = 4'd0;
        push_transfer(4'b1011, 4'd0, 4'd0);
        push_idle();
        @(negedge clock);
        sg.start = 1'b0;
        @(negedge clock);
        sg.start      = 1'b1;
        sg.pattern    = 4'b0000;
        sg.repeat_cnt = 4'd3;
        @(negedge clock);
        sg.start = 1'b0;
        wait_drain("busy_start");
        check("busy_start_done", 32'(obs_done), 32'd1);

        // start in the done cycle launches the next transfer with one idle cycle.
        @(negedge clock);
        sg.start      = 1'b1;
        sg.pattern    = 4'b1011;
        sg.repeat_cnt = 4'd0;
        sg.gap_len    = 4'd0;
        push_transfer(4'b1011, 4'd0, 4'd0);
        @(negedge clock);
        sg.start = 1'b0;
        repeat (FL) @(negedge clock);
        check("done_at_restart", {31'd0, sg.done}, 32'd1);
        sg.start   = 1'b1;
        sg.pattern = 4'b0110;
        push_transfer(4'b0110, 4'd0, 4'd0);
        push_idle();
        @(negedge clock);
        sg.start = 1'b0;
        wait_drain("restart");

        // Asynchronous reset between edges while the second bit is on the line.
        chk_en = 1'b0;
        @(negedge clock);
        sg.start      = 1'b1;
        sg.pattern    = 4'b1011;
        sg.repeat_cnt = 4'd2;
        sg.gap_len    = 4'd1;
        @(negedge clock);
        sg.start = 1'b0;
        @(posedge clock);
        #3;
        check("pre_reset_active", {30'd0, sg.dout_valid, sg.busy}, 32'd3);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {28'd0, sg.dout, sg.dout_valid, sg.busy, sg.done}, 32'd0);
        @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;
        obs_valid = 0;
        run_transfer(4'b1011, 4'd0, 4'd0);
        wait_drain("post_reset");
        check("post_reset_bits", 32'(obs_valid), 32'(FL));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
